// File: rtl/pe_group_feeder.sv
// pe_group_feeder: producer side of the PE-group interface.
// Buffers four rows of a row-major ifmap stream and presents one
// five-pixel vertical column per accepted pixel once rows 0..3 are held.
// At frame end the three-stage PE pipeline is flushed with zero columns.
// groupsum_valid marks the cycles in which the PE groupsum is valid.
module pe_group_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic signed [7:0] pix_data,
  output logic              pix_ready,
  input  logic              weight_wr_en,
  input  logic [2:0]        weight_wr_addr,
  input  logic signed [7:0] weight_wr_data,
  output logic signed [7:0] weight1_out,
  output logic signed [7:0] weight2_out,
  output logic signed [7:0] weight3_out,
  output logic signed [7:0] weight4_out,
  output logic signed [7:0] weight5_out,
  output logic              weight_en,
  output logic signed [7:0] ifmap_out1,
  output logic signed [7:0] ifmap_out2,
  output logic signed [7:0] ifmap_out3,
  output logic signed [7:0] ifmap_out4,
  output logic signed [7:0] ifmap_out5,
  output logic              calculate_en,
  output logic              groupsum_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] LAST_FILL_ROW = RW'(3);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [1:0]        r_drainCnt;
  logic              r_calcRun;
  logic [1:0]        r_vld;
  logic signed [7:0] r_lb [4][IMG_W];
  logic signed [7:0] r_wgt [5];

  logic w_accept;
  logic w_lastCol;
  logic w_wrTake;

  assign pix_ready = (r_state == S_FILL) || (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = pix_valid && pix_ready;
  assign w_lastCol = (r_col == LAST_COL);
  assign w_wrTake  = (r_state == S_IDLE) && weight_wr_en && (weight_wr_addr <= 3'd4);

  assign weight1_out = r_wgt[0];
  assign weight2_out = r_wgt[1];
  assign weight3_out = r_wgt[2];
  assign weight4_out = r_wgt[3];
  assign weight5_out = r_wgt[4];

  // Line buffers: each accepted pixel pushes its column one row deeper.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= pix_data;
      r_lb[1][r_col] <= r_lb[0][r_col];
      r_lb[2][r_col] <= r_lb[1][r_col];
      r_lb[3][r_col] <= r_lb[2][r_col];
    end
  end

  // Frame FSM with row/column tracking and the registered lane outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_drainCnt   <= '0;
      r_calcRun    <= 1'b0;
      calculate_en <= 1'b0;
      frame_done   <= 1'b0;
      ifmap_out1   <= '0;
      ifmap_out2   <= '0;
      ifmap_out3   <= '0;
      ifmap_out4   <= '0;
      ifmap_out5   <= '0;
    end else begin
      calculate_en <= 1'b0;
      r_calcRun    <= 1'b0;
      frame_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_FILL, S_RUN: begin
          if (w_accept) begin
            if (r_state == S_RUN) begin
              ifmap_out5   <= pix_data;
              ifmap_out4   <= r_lb[0][r_col];
              ifmap_out3   <= r_lb[1][r_col];
              ifmap_out2   <= r_lb[2][r_col];
              ifmap_out1   <= r_lb[3][r_col];
              calculate_en <= 1'b1;
              r_calcRun    <= 1'b1;
            end
            if (w_lastCol) begin
              r_col <= '0;
              if (r_state == S_RUN && r_row == LAST_ROW) begin
                r_row      <= '0;
                r_drainCnt <= '0;
                r_state    <= S_DRAIN;
              end else begin
                r_row <= r_row + 1'b1;
                if (r_state == S_FILL && r_row == LAST_FILL_ROW) begin
                  r_state <= S_RUN;
                end
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          calculate_en <= 1'b1;
          ifmap_out1   <= '0;
          ifmap_out2   <= '0;
          ifmap_out3   <= '0;
          ifmap_out4   <= '0;
          ifmap_out5   <= '0;
          if (r_drainCnt == 2'd2) begin
            r_drainCnt <= '0;
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_drainCnt <= r_drainCnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid pipe advancing with the PE; the groupsum_valid flop is its last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld          <= '0;
      groupsum_valid <= 1'b0;
    end else begin
      groupsum_valid <= calculate_en & r_vld[1];
      if (calculate_en) begin
        r_vld <= {r_vld[0], r_calcRun};
      end
    end
  end

  // Weight registers, writable only while idle, with a one-cycle update pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_en <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        r_wgt[i] <= '0;
      end
    end else begin
      weight_en <= w_wrTake;
      if (w_wrTake) begin
        case (weight_wr_addr)
          3'd0:    r_wgt[0] <= weight_wr_data;
          3'd1:    r_wgt[1] <= weight_wr_data;
          3'd2:    r_wgt[2] <= weight_wr_data;
          3'd3:    r_wgt[3] <= weight_wr_data;
          default: r_wgt[4] <= weight_wr_data;
        endcase
      end
    end
  end

endmodule

// File: doc/pe_group_feeder.md
Name: pe_group_feeder

Overview:
- Producer side of the PE-group interface; drives ifmap lanes, weights and calculate_en into one pe_group.
- Accepts a row-major 8-bit ifmap pixel stream over valid/ready and keeps 4 line buffers.
- Presents one 5-pixel vertical column per accepted pixel once 4 rows are buffered.
- Drains the 3-stage PE pipeline at frame end and flags when groupsum outputs are valid.

Parameters:
IMG_W, 28, pixels per row (≥2)
IMG_H, 28, rows per frame (≥5)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin frame; honoured in IDLE only
pix_valid  in  1  pixel stream valid
pix_data  in  8  signed pixel
pix_ready  out  1  feeder can accept pixel
weight_wr_en  in  1  weight register write strobe
weight_wr_addr  in  3  weight index 0..4; 5..7 ignored
weight_wr_data  in  8  signed weight
weight1_out..weight5_out  out  8 each  signed weight registers to PE group
weight_en  out  1  one-cycle pulse after any accepted weight write
ifmap_out1..ifmap_out5  out  8 each  column lanes; 1 = oldest row (r-4), 5 = current row r
calculate_en  out  1  PE advance enable
groupsum_valid  out  1  PE groupsum output valid this cycle
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset: state IDLE; all outputs 0, including weights; row/col counters 0; valid pipe 000. Line-buffer contents are don't-care. Reset mid-frame aborts immediately, and the next frame needs start.
- States:
  - IDLE: start → FILL.
  - FILL: rows 0..3 accepted; after the last pixel of row 3 → RUN.
  - RUN: rows 4..IMG_H-1; after the last pixel of the last row → DRAIN.
  - DRAIN: exactly 3 cycles → IDLE, with frame_done high in the cycle IDLE is entered.
- pix_ready: 1 in FILL and RUN; 0 in IDLE and DRAIN. Accept = pix_valid & pix_ready. No bubbles are required: one pixel per cycle is sustained.
- Counters:
  - col increments on accept and wraps IMG_W-1 → 0.
  - row increments on col wrap.
  - The final pixel is (IMG_H-1, IMG_W-1).
- Line buffers: 4 × IMG_W bytes. On accept at (r,c), lb[k][c] shifts (lb0 ← pix, lb1 ← lb0, …), so lb3[c] holds row r-4.
- Lane outputs: registered, 1-cycle latency.
  - On an accept in RUN: next cycle ifmap_out5 = pixel, ifmap_out4 = row r-1, …, ifmap_out1 = row r-4 at the same column; calculate_en = 1.
  - Accept in FILL: calculate_en = 0, lanes hold their previous value.
  - No accept: calculate_en = 0.
- DRAIN: calculate_en = 1 all 3 cycles with lanes forced to 0.
- Valid tracking: vld[2:0] shifts only on calculate_en cycles. vld[0] ← 1 for RUN columns and 0 for DRAIN columns.
  - groupsum_valid <= calculate_en & vld[1], registered.
  - So groupsum_valid is high exactly the cycle after the PE groupsum register captured a real column.
  - Total valid pulses per frame = IMG_W·(IMG_H-4).
- Weights:
  - Writes are accepted only in IDLE with addr ≤4; they are ignored otherwise, with no register change and no weight_en.
  - weightN_out = reg[N-1], stable for the whole frame.
- Simultaneous events:
  - start and weight_wr_en in the same IDLE cycle: the write is taken and the state moves to FILL.
  - start outside IDLE is ignored.
  - rst wins over everything.
- Arithmetic: no arithmetic on data beyond moves. Widths are exactly 8 bits, signed, passed unchanged.

Test Plan:
- Reset/weights: rst, then write addr 0..4 = 1,-2,3,-4,5 and addr 6 = 9. Required: weight1..5_out = 1,-2,3,-4,5; five weight_en pulses; addr 6 has no effect. A write while busy is ignored.
- Fill (IMG_W=4, IMG_H=6): start, then pixels 0..15 back-to-back. Required: calculate_en stays 0; state is RUN after pixel 15; pix_ready stays 1.
- Run columns: pixels 16..23 continue with value = index. Required: one cycle after accepting pixel 16, lanes = 0,4,8,12,16; after pixel 23, lanes = 7,11,15,19,23; calculate_en = 1 for each.
- Drain/valid: frame ends after pixel 23. Required: pix_ready = 0; 3 DRAIN cycles with calculate_en = 1 and lanes = 0; exactly 8 groupsum_valid pulses, the first 3 cycles after the first RUN accept; frame_done pulse; busy = 0.
- Backpressure: pix_valid toggles 1,0,0,1 during RUN. Required: calculate_en follows the accepts delayed by one cycle, and groupsum_valid only advances on calculate_en cycles.
- Reset mid-RUN: assert rst after pixel 18. Required: next cycle IDLE, all outputs 0, pix_ready = 0; a new start restarts FILL at row 0.
